// File: rtl/vliw_fetch_pkg.sv
// Shared definitions for the fetch/align stage: widths, parcel encodings, FSM states.
package vliw_fetch_pkg;

  localparam int PC_W     = 5;
  localparam int PARCEL_W = 16;
  localparam int WIN_W    = 48;

  // Low two bits of the first parcel equal to this mark a 32-bit instruction.
  localparam logic [1:0]          LEN32_CODE = 2'b11;
  localparam logic [PARCEL_W-1:0] NOP_PARCEL = 16'h0000;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    END = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifetch_len_decode.sv
// Combinational length decode of the fetch window: classifies the parcel at pc
// and assembles the aligned 32-bit instruction word.
import vliw_fetch_pkg::*;

module ifetch_len_decode (
  input  logic [WIN_W-1:0] IR,
  output logic             is16,
  output logic             is_pad,
  output logic [31:0]      instr32,
  output logic [1:0]       adv
);

  logic [PARCEL_W-1:0] p0;
  logic [PARCEL_W-1:0] p1;
  logic                unused_p2;

  assign p0 = IR[PARCEL_W-1:0];
  assign p1 = IR[2*PARCEL_W-1:PARCEL_W];
  // The third parcel is only provided by the memory for wider future formats.
  assign unused_p2 = ^IR[WIN_W-1:2*PARCEL_W];

  // Classify the first parcel and build the zero-extended or full instruction.
  always_comb begin
    is16    = (p0[1:0] != LEN32_CODE);
    is_pad  = (p0 == NOP_PARCEL);
    instr32 = is16 ? {16'h0000, p0} : {p1, p0};
    adv     = is16 ? 2'd1 : 2'd2;
  end

endmodule

// File: rtl/ifetch_align.sv
// Fetch/align stage: walks the parcel memory, splits compact/full instructions
// and hands one aligned instruction per cycle to decode over valid/ready.
// Optional macro IFETCH_NOP_SKIP_EN: when defined, zero padding parcels are
// skipped instead of being issued as compact zero instructions.
//
// state | meaning
// RUN   | fetching and issuing instructions
// END   | last parcel consumed or straddling instruction found; pc frozen
import vliw_fetch_pkg::*;

module ifetch_align (
  input  logic             clk,
  input  logic             reset,
  output logic [PC_W-1:0]  pc_5bits,
  input  logic [WIN_W-1:0] IR,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic             instr_is16,
  output logic [PC_W-1:0]  instr_pc,
  output logic             fetch_done,
  output logic             fetch_err
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic            dec_is16;
  logic            dec_pad;
  logic [31:0]     dec_instr;
  logic [1:0]      dec_adv;
  logic            pad;
  logic [PC_W:0]   pc_next_ext;
  logic            last_hit;
  logic            straddle;
  logic            slot_free;

  ifetch_len_decode u_len_decode (
    .IR      (IR),
    .is16    (dec_is16),
    .is_pad  (dec_pad),
    .instr32 (dec_instr),
    .adv     (dec_adv)
  );

`ifdef IFETCH_NOP_SKIP_EN
  assign pad = dec_pad;
`else
  logic unused_pad;
  assign unused_pad = dec_pad;
  assign pad        = 1'b0;
`endif

  assign pc_5bits = pc;

  // Extra carry bit detects consuming the last parcel without wrapping pc.
  always_comb begin
    pc_next_ext = {1'b0, pc} + {{(PC_W-1){1'b0}}, dec_adv};
    last_hit    = pc_next_ext[PC_W];
    straddle    = !dec_is16 && (pc == {PC_W{1'b1}});
    slot_free   = !instr_valid || instr_ready;
  end

  // Fetch FSM, pc and output register; redirect overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_is16  <= 1'b0;
      instr_pc    <= '0;
      fetch_done  <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (redirect_valid) begin
      state       <= RUN;
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
      fetch_done  <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (slot_free) begin
            if (straddle) begin
              instr_valid <= 1'b0;
              fetch_err   <= 1'b1;
              fetch_done  <= 1'b1;
              state       <= END;
            end else begin
              if (pad) begin
                instr_valid <= 1'b0;
              end else begin
                instr_valid <= 1'b1;
                instr       <= dec_instr;
                instr_is16  <= dec_is16;
                instr_pc    <= pc;
              end
              // pc stays on the last parcel rather than wrapping to 0.
              if (last_hit) begin
                fetch_done <= 1'b1;
                state      <= END;
              end else begin
                pc <= pc_next_ext[PC_W-1:0];
              end
            end
          end
        end
        END: begin
          if (instr_ready) instr_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
